// File: rtl/pipeline_hazard_ctrl.sv
// Control-field pipeline registers and hazard unit for the five-stage core:
// forwarding selects, load-use bubble, branch flush and double-access freeze.
//
// state      | meaning
// ST_IDLE    | no double access pending; a double op in MEM starts a freeze
// ST_WAIT    | freezing; cnt counts the remaining freeze cycles down to 0
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W    = 3,
  parameter int EX_CTRL_W     = 5,
  parameter int MEM_CTRL_W    = 5,
  parameter int WB_CTRL_W     = 2,
  parameter int MEM_WAIT      = 1,
  parameter int ZERO_REG_HARD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [EX_CTRL_W-1:0]  id_ctrl_ex,
  input  logic [MEM_CTRL_W-1:0] id_ctrl_mem,
  input  logic [WB_CTRL_W-1:0]  id_ctrl_wb,
  input  logic                  mem_branch_taken,
  output logic [EX_CTRL_W-1:0]  ex_ctrl,
  output logic [MEM_CTRL_W-1:0] mem_ctrl,
  output logic [WB_CTRL_W-1:0]  wb_ctrl,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_hold,
  output logic                  mem_freeze
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [3:0] CNT_INIT = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  logic [EX_CTRL_W-1:0]  idex_ex;
  logic [MEM_CTRL_W-1:0] idex_mem;
  logic [WB_CTRL_W-1:0]  idex_wb;
  logic [REG_ADDR_W-1:0] idex_rs1;
  logic [REG_ADDR_W-1:0] idex_rs2;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic                  idex_use1;
  logic                  idex_use2;

  logic [MEM_CTRL_W-1:0] exmem_mem;
  logic [WB_CTRL_W-1:0]  exmem_wb;
  logic [REG_ADDR_W-1:0] exmem_rd;

  logic [WB_CTRL_W-1:0]  memwb_wb;
  logic [REG_ADDR_W-1:0] memwb_rd;

  logic [0:0] state;
  logic [3:0] cnt;

  logic       dbl;
  logic       freeze;
  logic       load_use;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  function automatic logic match(input logic [REG_ADDR_W-1:0] a,
                                 input logic [REG_ADDR_W-1:0] b);
    return (a == b) && !((ZERO_REG_HARD != 0) && (a == '0));
  endfunction

  always_comb begin
    dbl    = exmem_mem[3] | exmem_mem[4];
    freeze = 1'b0;
    case (state)
      ST_IDLE: freeze = dbl && (MEM_WAIT != 0);
      ST_WAIT: freeze = (cnt != 4'd0);
      default: freeze = 1'b0;
    endcase
  end

  always_comb begin
    load_use = idex_wb[0] && idex_wb[1] &&
               ((id_use_rs1 && match(idex_rd, id_rs1)) ||
                (id_use_rs2 && match(idex_rd, id_rs2)));
  end

  // EX_MEM result is newer than WB data, so it wins when both match
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (idex_use1) begin
      if (exmem_wb[0] && match(exmem_rd, idex_rs1))      sel_a = 2'b01;
      else if (memwb_wb[0] && match(memwb_rd, idex_rs1)) sel_a = 2'b10;
    end
    if (idex_use2) begin
      if (exmem_wb[0] && match(exmem_rd, idex_rs2))      sel_b = 2'b01;
      else if (memwb_wb[0] && match(memwb_rd, idex_rs2)) sel_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dbl && (MEM_WAIT != 0)) begin
            state <= ST_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) cnt   <= cnt - 4'd1;
          else             state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Bubbles and flushes clear the whole ID_EX entry so a NOP reads no sources
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ex   <= '0;
      idex_mem  <= '0;
      idex_wb   <= '0;
      idex_rs1  <= '0;
      idex_rs2  <= '0;
      idex_rd   <= '0;
      idex_use1 <= 1'b0;
      idex_use2 <= 1'b0;
      exmem_mem <= '0;
      exmem_wb  <= '0;
      exmem_rd  <= '0;
      memwb_wb  <= '0;
      memwb_rd  <= '0;
    end else if (freeze) begin
      memwb_wb <= '0;
      memwb_rd <= '0;
    end else begin
      memwb_wb <= exmem_wb;
      memwb_rd <= exmem_rd;
      if (mem_branch_taken) begin
        exmem_mem <= '0;
        exmem_wb  <= '0;
        exmem_rd  <= '0;
      end else begin
        exmem_mem <= idex_mem;
        exmem_wb  <= idex_wb;
        exmem_rd  <= idex_rd;
      end
      if (mem_branch_taken || load_use) begin
        idex_ex   <= '0;
        idex_mem  <= '0;
        idex_wb   <= '0;
        idex_rs1  <= '0;
        idex_rs2  <= '0;
        idex_rd   <= '0;
        idex_use1 <= 1'b0;
        idex_use2 <= 1'b0;
      end else begin
        idex_ex   <= id_ctrl_ex;
        idex_mem  <= id_ctrl_mem;
        idex_wb   <= id_ctrl_wb;
        idex_rs1  <= id_rs1;
        idex_rs2  <= id_rs2;
        idex_rd   <= id_rd;
        idex_use1 <= id_use_rs1;
        idex_use2 <= id_use_rs2;
      end
    end
  end

  assign ex_ctrl     = idex_ex;
  assign mem_ctrl    = exmem_mem;
  assign wb_ctrl     = memwb_wb;
  assign wb_rd       = memwb_rd;
  assign fwd_a       = rst ? 2'b00 : sel_a;
  assign fwd_b       = rst ? 2'b00 : sel_b;
  assign mem_freeze  = !rst && freeze;
  assign id_ex_hold  = !rst && freeze;
  assign pc_hold     = !rst && (freeze || (load_use && !mem_branch_taken));
  assign if_id_hold  = pc_hold;
  assign if_id_flush = !rst && !freeze && mem_branch_taken;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench: two hazard-unit configurations against an instruction-level
// pipeline model (stage slots plus a per-op remaining-freeze count).
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [4:0] ex;
    logic [4:0] mem;
    logic [1:0] wb;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       u1;
    logic       u2;
    logic [2:0] rd;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2;
  logic [4:0] id_ctrl_ex, id_ctrl_mem;
  logic [1:0] id_ctrl_wb;
  logic       mem_branch_taken;

  logic [4:0] ex_ctrl_o  [2];
  logic [4:0] mem_ctrl_o [2];
  logic [1:0] wb_ctrl_o  [2];
  logic [2:0] wb_rd_o    [2];
  logic [1:0] fwd_a_o    [2];
  logic [1:0] fwd_b_o    [2];
  logic       pc_hold_o  [2];
  logic       if_hold_o  [2];
  logic       flush_o    [2];
  logic       idex_hold_o[2];
  logic       freeze_o   [2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_WAIT(3), .ZERO_REG_HARD(1)) u_dut0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl_ex(id_ctrl_ex),
    .id_ctrl_mem(id_ctrl_mem), .id_ctrl_wb(id_ctrl_wb), .mem_branch_taken(mem_branch_taken),
    .ex_ctrl(ex_ctrl_o[0]), .mem_ctrl(mem_ctrl_o[0]), .wb_ctrl(wb_ctrl_o[0]), .wb_rd(wb_rd_o[0]),
    .fwd_a(fwd_a_o[0]), .fwd_b(fwd_b_o[0]), .pc_hold(pc_hold_o[0]), .if_id_hold(if_hold_o[0]),
    .if_id_flush(flush_o[0]), .id_ex_hold(idex_hold_o[0]), .mem_freeze(freeze_o[0]));

  pipeline_hazard_ctrl #(.MEM_WAIT(0), .ZERO_REG_HARD(0)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl_ex(id_ctrl_ex),
    .id_ctrl_mem(id_ctrl_mem), .id_ctrl_wb(id_ctrl_wb), .mem_branch_taken(mem_branch_taken),
    .ex_ctrl(ex_ctrl_o[1]), .mem_ctrl(mem_ctrl_o[1]), .wb_ctrl(wb_ctrl_o[1]), .wb_rd(wb_rd_o[1]),
    .fwd_a(fwd_a_o[1]), .fwd_b(fwd_b_o[1]), .pc_hold(pc_hold_o[1]), .if_id_hold(if_hold_o[1]),
    .if_id_flush(flush_o[1]), .id_ex_hold(idex_hold_o[1]), .mem_freeze(freeze_o[1]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [2:0] a, input logic [2:0] b, input int zr);
    return (a == b) && !(zr != 0 && a == 3'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input instr_t m, input instr_t w, input logic [2:0] src,
                                         input logic use_src, input int zr);
    if (!use_src) return 2'b00;
    if (m.wb[0] && hit(m.rd, src, zr)) return 2'b01;
    if (w.wb[0] && hit(w.rd, src, zr)) return 2'b10;
    return 2'b00;
  endfunction

  instr_t ex_s [2];
  instr_t mem_s[2];
  instr_t wb_s [2];
  int     rem  [2];
  int     mw   [2];
  int     zr   [2];
  logic   fz   [2];
  logic   lu   [2];
  int     frz_seen;

  initial begin
    instr_t id_i;
    logic   hold_e, flush_e, frz_e;
    mw = '{3, 0};
    zr = '{1, 0};
    frz_seen = 0;
    for (int k = 0; k < 2; k++) begin
      ex_s[k] = '0; mem_s[k] = '0; wb_s[k] = '0; rem[k] = 0;
    end
    rst = 1'b1;
    {id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2} = '0;
    {id_ctrl_ex, id_ctrl_mem, id_ctrl_wb, mem_branch_taken} = '0;
    @(posedge clk);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst              = (cyc < 2) || ($urandom_range(0, 59) == 0);
      id_rs1           = 3'($urandom_range(0, 3));
      id_rs2           = 3'($urandom_range(0, 3));
      id_rd            = 3'($urandom_range(0, 3));
      id_use_rs1       = 1'($urandom_range(0, 3) != 0);
      id_use_rs2       = 1'($urandom_range(0, 1));
      id_ctrl_ex       = 5'($urandom);
      id_ctrl_mem      = 5'($urandom) & (($urandom_range(0, 5) == 0) ? 5'h1f : 5'h07);
      id_ctrl_wb       = 2'($urandom);
      mem_branch_taken = ($urandom_range(0, 7) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        fz[k] = (rem[k] > 0);
        lu[k] = (ex_s[k].wb == 2'b11) &&
                ((id_use_rs1 && hit(ex_s[k].rd, id_rs1, zr[k])) ||
                 (id_use_rs2 && hit(ex_s[k].rd, id_rs2, zr[k])));
        hold_e  = !rst && (fz[k] || (lu[k] && !mem_branch_taken));
        flush_e = !rst && !fz[k] && mem_branch_taken;
        frz_e   = !rst && fz[k];
        if (frz_e && k == 0) frz_seen++;
        check_eq($sformatf("u%0d ex_ctrl", k),  32'(ex_ctrl_o[k]),  32'(ex_s[k].ex));
        check_eq($sformatf("u%0d mem_ctrl", k), 32'(mem_ctrl_o[k]), 32'(mem_s[k].mem));
        check_eq($sformatf("u%0d wb_ctrl", k),  32'(wb_ctrl_o[k]),  32'(wb_s[k].wb));
        check_eq($sformatf("u%0d wb_rd", k),    32'(wb_rd_o[k]),    32'(wb_s[k].rd));
        check_eq($sformatf("u%0d fwd_a", k), 32'(fwd_a_o[k]),
                 rst ? 32'd0 : 32'(fwd_sel(mem_s[k], wb_s[k], ex_s[k].rs1, ex_s[k].u1, zr[k])));
        check_eq($sformatf("u%0d fwd_b", k), 32'(fwd_b_o[k]),
                 rst ? 32'd0 : 32'(fwd_sel(mem_s[k], wb_s[k], ex_s[k].rs2, ex_s[k].u2, zr[k])));
        check_eq($sformatf("u%0d pc_hold", k),     32'(pc_hold_o[k]),   32'(hold_e));
        check_eq($sformatf("u%0d if_id_hold", k),  32'(if_hold_o[k]),   32'(hold_e));
        check_eq($sformatf("u%0d if_id_flush", k), 32'(flush_o[k]),     32'(flush_e));
        check_eq($sformatf("u%0d id_ex_hold", k),  32'(idex_hold_o[k]), 32'(frz_e));
        check_eq($sformatf("u%0d mem_freeze", k),  32'(freeze_o[k]),    32'(frz_e));
      end

      @(posedge clk);
      id_i = '{ex: id_ctrl_ex, mem: id_ctrl_mem, wb: id_ctrl_wb, rs1: id_rs1, rs2: id_rs2,
                u1: id_use_rs1, u2: id_use_rs2, rd: id_rd};
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          ex_s[k] = '0; mem_s[k] = '0; wb_s[k] = '0; rem[k] = 0;
        end else if (fz[k]) begin
          wb_s[k] = '0;
          rem[k]--;
        end else begin
          wb_s[k] = mem_s[k];
          if (mem_branch_taken) begin
            mem_s[k] = '0;
            ex_s[k]  = '0;
          end else if (lu[k]) begin
            mem_s[k] = ex_s[k];
            ex_s[k]  = '0;
          end else begin
            mem_s[k] = ex_s[k];
            ex_s[k]  = id_i;
          end
          // a double access that just arrived in MEM owes MEM_WAIT frozen cycles
          if (mem_s[k].mem[3] || mem_s[k].mem[4]) rem[k] = mw[k];
        end
      end
    end

    check_eq("freeze_exercised", 32'(frz_seen > 0), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised pipeline control and hazard unit for the five-stage IF/ID/EX/MEM/WB core.
- Owns the stage-to-stage control-field registers: ID_EX, EX_MEM and MEM_WB WB/MEM/EX bits, plus the tracked register addresses.
- Generates EX-stage forwarding selects, load-use stall with bubble, taken-branch flush, and a multi-cycle freeze for doubleRead/doubleWrite memory accesses.
- Datapath stage registers outside this block obey its hold, flush and bubble outputs.

Parameters:
- REG_ADDR_W, 3, register-file address width.
- EX_CTRL_W, 5, EX control field width (ALU op and ALU src).
- MEM_CTRL_W, 5, MEM control field width: [0] jump, [1] BNE, [2] MemWrite, [3] doubleWrite, [4] doubleRead.
- WB_CTRL_W, 2, WB control field width: [0] RegWrite, [1] MemToReg.
- MEM_WAIT, 1, extra freeze cycles per double access; 0 disables the freeze. Range 0..15.
- ZERO_REG_HARD, 1, 1 = register 0 is hardwired zero and never forwards or stalls.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID.
- id_rd  in  REG_ADDR_W  target register of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_ctrl_ex  in  EX_CTRL_W  decoded EX field.
- id_ctrl_mem  in  MEM_CTRL_W  decoded MEM field.
- id_ctrl_wb  in  WB_CTRL_W  decoded WB field.
- mem_branch_taken  in  1  pc_src from the MEM stage.
- ex_ctrl  out  EX_CTRL_W  registered ID_EX EX field.
- mem_ctrl  out  MEM_CTRL_W  registered EX_MEM MEM field.
- wb_ctrl  out  WB_CTRL_W  registered MEM_WB WB field.
- wb_rd  out  REG_ADDR_W  MEM_WB target register.
- fwd_a  out  2  ALU operand A select: 00 ID_EX data, 01 EX_MEM ALU result, 10 WB data.
- fwd_b  out  2  ALU operand B select, same encoding as fwd_a.
- pc_hold  out  1  PC keeps its value.
- if_id_hold  out  1  IF_ID keeps its value.
- if_id_flush  out  1  IF_ID loads a NOP.
- id_ex_hold  out  1  ID_EX datapath holds.
- mem_freeze  out  1  whole pipeline frozen; EX_MEM holds, MEM_WB loads a bubble.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All control registers and register addresses go to 0; FSM goes to IDLE with cnt=0.
  - Every output is 0 during and after reset until new inputs propagate.
  - Reset mid-freeze aborts the freeze immediately.
- Internal registers:
  - ID_EX holds {ctrl_ex, ctrl_mem, ctrl_wb, rs1, rs2, use1, use2, rd}.
  - EX_MEM holds {ctrl_mem, ctrl_wb, rd}.
  - MEM_WB holds {ctrl_wb, rd}.
  - Each advances one stage per cycle when no hold applies (latency 1 per stage).
- match(a, b) = (a == b) and not (ZERO_REG_HARD and a == 0).
- Forwarding (combinational, from registered state):
  - fwd_a = 01 if EX_MEM RegWrite and match(EX_MEM.rd, ID_EX.rs1) and ID_EX.use1.
  - Otherwise fwd_a = 10 if MEM_WB RegWrite and match(MEM_WB.rd, ID_EX.rs1) and ID_EX.use1.
  - Otherwise fwd_a = 00.
  - fwd_b is the same rule using rs2/use2.
  - EX_MEM has priority over MEM_WB.
- load_use = ID_EX RegWrite and MemToReg, and either (id_use_rs1 and match(ID_EX.rd, id_rs1)) or (id_use_rs2 and match(ID_EX.rd, id_rs2)).
- Freeze FSM:
  - dbl = mem_ctrl[3] or mem_ctrl[4].
  - IDLE: if dbl and MEM_WAIT > 0, assert freeze this cycle, go to WAIT, cnt = MEM_WAIT-1.
  - WAIT with cnt != 0: freeze, cnt--.
  - WAIT with cnt == 0: no freeze, go to IDLE; the double op advances to MEM_WB.
  - Total freeze = exactly MEM_WAIT cycles per double op. No retrigger on the same op.
- Priority per cycle (highest first):
  - freeze: PC, IF_ID, ID_EX and EX_MEM hold; MEM_WB takes a zero ctrl bubble. Branch and load-use are ignored; mem_branch_taken is sampled only on a non-frozen cycle.
  - mem_branch_taken: if_id_flush=1; ID_EX and EX_MEM control load 0 next edge; PC takes the branch target (no pc_hold).
  - load_use: pc_hold=if_id_hold=1; ID_EX control loads 0 (bubble); EX_MEM and MEM_WB advance. Lasts exactly 1 cycle.
  - otherwise all stages advance.
- Output mapping:
  - mem_freeze equals the freeze term.
  - id_ex_hold = freeze.
  - pc_hold = if_id_hold = freeze or (load_use and not mem_branch_taken).

Test Plan:
- rst=1 for 2 cycles, then random id_* inputs -> all outputs 0 during reset; ex_ctrl equals the prior cycle's id_ctrl_ex one cycle after release.
- ADD r1 followed by ADD using r1 as rs1 -> fwd_a=01 in the consumer's EX cycle. With one independent op between them -> fwd_a=10. rd=0 with ZERO_REG_HARD=1 -> fwd_a=00.
- LOAD r2 followed by SUB using r2 as rs2 -> pc_hold=if_id_hold=1 for exactly 1 cycle and ex_ctrl=0 next cycle. Next cycle fwd_b=10.
- BNE taken (mem_branch_taken=1) while a load-use pair sits in ID/EX -> if_id_flush=1, pc_hold=0. ex_ctrl=0 and mem_ctrl=0 next cycle.
- doubleRead with MEM_WAIT=3 -> mem_freeze high for exactly 3 cycles; mem_ctrl stable and wb_ctrl=0 during the freeze; the op reaches MEM_WB on cycle 4. MEM_WAIT=0 -> no freeze.
- rst asserted on the 2nd freeze cycle -> mem_freeze=0 next cycle; FSM in IDLE; no residual freeze.
